// File: rtl/sram_tp_reg_array_pkg.sv
// Shared helpers for the flip-flop two-port register array.
package sram_tp_reg_array_pkg;

   function automatic int clog2(input int n);
      int w;
      w = 0;
      while ((1 << w) < n) w++;
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/sram_tp_reg_dout_stage.sv
// Read-output register: valid follows the input every cycle, data loads only on valid.
module sram_tp_reg_dout_stage #(
   parameter int DATA_WD = 8
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               val_i,
   input  logic [DATA_WD-1:0] dat_i,
   output logic               val_o,
   output logic [DATA_WD-1:0] dat_o
);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         val_o <= 1'b0;
         dat_o <= '0;
      end else begin
         val_o <= val_i;
         if (val_i) dat_o <= dat_i;
      end
   end

endmodule

// File: rtl/sram_tp_reg_array.sv
// Two-port flip-flop memory, 1 write + 1 read per cycle, read latency 1 or 2 (KNOB_REGOUT).
// Define SRAM_TP_REG_WR_FWD_EN for write-through on a same-cycle same-address read.
module sram_tp_reg_array
   import sram_tp_reg_array_pkg::*;
#(
   parameter  int KNOB_REGOUT = 0,
   parameter  int SIZE        = 4,
   parameter  int DATA_WD     = 8,
   localparam int ADR_WD      = clog2(SIZE)
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               wr_val_i,
   input  logic [ADR_WD-1:0]  wr_adr_i,
   input  logic [DATA_WD-1:0] wr_dat_i,
   input  logic               rd_val_i,
   input  logic [ADR_WD-1:0]  rd_adr_i,
   output logic               rd_val_o,
   output logic [DATA_WD-1:0] rd_dat_o
);

   logic [DATA_WD-1:0] mem [SIZE];
   logic [DATA_WD-1:0] rd_dat_c;
   logic               s1_val;
   logic [DATA_WD-1:0] s1_dat;

   // Decode by comparing against each word index so addresses >= SIZE match nothing.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < SIZE; i++) mem[i] <= '0;
      end else if (wr_val_i) begin
         for (int i = 0; i < SIZE; i++)
            if (wr_adr_i == ADR_WD'(i)) mem[i] <= wr_dat_i;
      end
   end

   always_comb begin
      rd_dat_c = '0;
      for (int i = 0; i < SIZE; i++) begin
         if (rd_adr_i == ADR_WD'(i)) begin
`ifdef SRAM_TP_REG_WR_FWD_EN
            if (wr_val_i && (wr_adr_i == rd_adr_i)) rd_dat_c = wr_dat_i;
            else                                    rd_dat_c = mem[i];
`else
            rd_dat_c = mem[i];
`endif
         end
      end
   end

   sram_tp_reg_dout_stage #(.DATA_WD(DATA_WD)) u_stage1 (
      .clk   (clk),
      .rstn  (rstn),
      .val_i (rd_val_i),
      .dat_i (rd_dat_c),
      .val_o (s1_val),
      .dat_o (s1_dat)
   );

   generate
      if (KNOB_REGOUT == 1) begin : g_regout
         sram_tp_reg_dout_stage #(.DATA_WD(DATA_WD)) u_stage2 (
            .clk   (clk),
            .rstn  (rstn),
            .val_i (s1_val),
            .dat_i (s1_dat),
            .val_o (rd_val_o),
            .dat_o (rd_dat_o)
         );
      end else begin : g_direct
         assign rd_val_o = s1_val;
         assign rd_dat_o = s1_dat;
      end
   endgenerate

endmodule

// File: tb/tb_sram_tp_reg_array.sv
// Directed bench: latency-1 SIZE=4, latency-2 SIZE=4 and latency-1 SIZE=5 instances.
module tb_sram_tp_reg_array;

   logic clk;
   logic rstn;
   int   checks;
   int   errors;

   // a: KNOB_REGOUT=0 SIZE=4 ; b: KNOB_REGOUT=1 SIZE=4 ; c: KNOB_REGOUT=0 SIZE=5
   logic       a_wr_val, a_rd_val, a_rd_val_o;
   logic [1:0] a_wr_adr, a_rd_adr;
   logic [7:0] a_wr_dat, a_rd_dat_o;
   logic       b_wr_val, b_rd_val, b_rd_val_o;
   logic [1:0] b_wr_adr, b_rd_adr;
   logic [7:0] b_wr_dat, b_rd_dat_o;
   logic       c_wr_val, c_rd_val, c_rd_val_o;
   logic [2:0] c_wr_adr, c_rd_adr;
   logic [7:0] c_wr_dat, c_rd_dat_o;

   sram_tp_reg_array #(.KNOB_REGOUT(0), .SIZE(4), .DATA_WD(8)) u_dut_a (
      .clk(clk), .rstn(rstn),
      .wr_val_i(a_wr_val), .wr_adr_i(a_wr_adr), .wr_dat_i(a_wr_dat),
      .rd_val_i(a_rd_val), .rd_adr_i(a_rd_adr),
      .rd_val_o(a_rd_val_o), .rd_dat_o(a_rd_dat_o)
   );

   sram_tp_reg_array #(.KNOB_REGOUT(1), .SIZE(4), .DATA_WD(8)) u_dut_b (
      .clk(clk), .rstn(rstn),
      .wr_val_i(b_wr_val), .wr_adr_i(b_wr_adr), .wr_dat_i(b_wr_dat),
      .rd_val_i(b_rd_val), .rd_adr_i(b_rd_adr),
      .rd_val_o(b_rd_val_o), .rd_dat_o(b_rd_dat_o)
   );

   sram_tp_reg_array #(.KNOB_REGOUT(0), .SIZE(5), .DATA_WD(8)) u_dut_c (
      .clk(clk), .rstn(rstn),
      .wr_val_i(c_wr_val), .wr_adr_i(c_wr_adr), .wr_dat_i(c_wr_dat),
      .rd_val_i(c_rd_val), .rd_adr_i(c_rd_adr),
      .rd_val_o(c_rd_val_o), .rd_dat_o(c_rd_dat_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [7:0] dexp;
      rstn = 1'b0;
      cyc(); cyc();
      checks++;
      if (a_rd_val_o !== 1'b0 || a_rd_dat_o !== 8'h00) begin
         errors++;
         $display("FAIL reset_a: val=%b dat=%h, required val=0 dat=00", a_rd_val_o, a_rd_dat_o);
      end
      checks++;
      if (b_rd_val_o !== 1'b0 || b_rd_dat_o !== 8'h00) begin
         errors++;
         $display("FAIL reset_b: val=%b dat=%h, required val=0 dat=00", b_rd_val_o, b_rd_dat_o);
      end
      rstn = 1'b1;
      cyc();
      dexp = 8'h00;
      for (int i = 0; i < 4; i++) begin
         a_rd_val = 1'b1;
         a_rd_adr = 2'(i);
         cyc();
         checks++;
         if (a_rd_val_o !== 1'b1 || a_rd_dat_o !== dexp) begin
            errors++;
            $display("FAIL reset_read[%0d]: val=%b dat=%h, required val=1 dat=%h", i, a_rd_val_o, a_rd_dat_o, dexp);
         end
      end
      a_rd_val = 1'b0;
      cyc();
      checks++;
      if (a_rd_val_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_read_end: val=%b, required 0", a_rd_val_o);
      end
   endtask

   task automatic test_fill_readback();
      logic [7:0] wdat [4];
      wdat[0] = 8'h11; wdat[1] = 8'h22; wdat[2] = 8'h33; wdat[3] = 8'h44;
      for (int i = 0; i < 4; i++) begin
         a_wr_val = 1'b1; a_wr_adr = 2'(i); a_wr_dat = wdat[i];
         b_wr_val = 1'b1; b_wr_adr = 2'(i); b_wr_dat = wdat[i];
         cyc();
      end
      a_wr_val = 1'b0;
      b_wr_val = 1'b0;
      for (int i = 3; i >= 0; i--) begin
         a_rd_val = 1'b1;
         a_rd_adr = 2'(i);
         cyc();
         checks++;
         if (a_rd_val_o !== 1'b1 || a_rd_dat_o !== wdat[i]) begin
            errors++;
            $display("FAIL readback[%0d]: val=%b dat=%h, required val=1 dat=%h", i, a_rd_val_o, a_rd_dat_o, wdat[i]);
         end
      end
      a_rd_val = 1'b0;
      cyc();
      checks++;
      if (a_rd_val_o !== 1'b0 || a_rd_dat_o !== 8'h11) begin
         errors++;
         $display("FAIL readback_hold: val=%b dat=%h, required val=0 dat=11", a_rd_val_o, a_rd_dat_o);
      end
   endtask

   task automatic test_collision();
      logic [7:0] first_exp;
`ifdef SRAM_TP_REG_WR_FWD_EN
      first_exp = 8'h55;
`else
      first_exp = 8'hAA;
`endif
      a_wr_val = 1'b1; a_wr_adr = 2'd2; a_wr_dat = 8'hAA;
      cyc();
      a_wr_dat = 8'h55;
      a_rd_val = 1'b1; a_rd_adr = 2'd2;
      cyc();
      a_wr_val = 1'b0;
      checks++;
      if (a_rd_val_o !== 1'b1 || a_rd_dat_o !== first_exp) begin
         errors++;
         $display("FAIL collision_same_cycle: val=%b dat=%h, required val=1 dat=%h", a_rd_val_o, a_rd_dat_o, first_exp);
      end
      cyc();
      checks++;
      if (a_rd_val_o !== 1'b1 || a_rd_dat_o !== 8'h55) begin
         errors++;
         $display("FAIL collision_next_read: val=%b dat=%h, required val=1 dat=55", a_rd_val_o, a_rd_dat_o);
      end
      a_rd_val = 1'b0;
      cyc();
   endtask

   task automatic test_latency();
      b_rd_val = 1'b1; b_rd_adr = 2'd1;
      cyc();
      b_rd_val = 1'b0;
      checks++;
      if (b_rd_val_o !== 1'b0) begin
         errors++;
         $display("FAIL latency_early: val=%b, required 0", b_rd_val_o);
      end
      cyc();
      checks++;
      if (b_rd_val_o !== 1'b1 || b_rd_dat_o !== 8'h22) begin
         errors++;
         $display("FAIL latency_data: val=%b dat=%h, required val=1 dat=22", b_rd_val_o, b_rd_dat_o);
      end
      for (int k = 0; k < 2; k++) begin
         cyc();
         checks++;
         if (b_rd_val_o !== 1'b0 || b_rd_dat_o !== 8'h22) begin
            errors++;
            $display("FAIL latency_hold[%0d]: val=%b dat=%h, required val=0 dat=22", k, b_rd_val_o, b_rd_dat_o);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] wdat [4];
      logic       vexp;
      logic [7:0] dexp;
      wdat[0] = 8'h11; wdat[1] = 8'h22; wdat[2] = 8'h33; wdat[3] = 8'h44;
      dexp = 8'h22;
      for (int k = 1; k <= 6; k++) begin
         b_rd_val = (k <= 4);
         b_rd_adr = 2'(k - 1);
         cyc();
         vexp = (k >= 2) && (k <= 5);
         if (vexp) dexp = wdat[k-2];
         checks++;
         if (b_rd_val_o !== vexp || b_rd_dat_o !== dexp) begin
            errors++;
            $display("FAIL back_to_back[%0d]: val=%b dat=%h, required val=%b dat=%h", k, b_rd_val_o, b_rd_dat_o, vexp, dexp);
         end
      end
      b_rd_val = 1'b0;
   endtask

   task automatic test_nonpow2();
      logic [7:0] dexp;
      for (int i = 0; i < 5; i++) begin
         c_wr_val = 1'b1; c_wr_adr = 3'(i); c_wr_dat = 8'hA0 + 8'(i);
         cyc();
      end
      c_wr_adr = 3'd7; c_wr_dat = 8'h77;
      cyc();
      c_wr_adr = 3'd5; c_wr_dat = 8'h66;
      cyc();
      c_wr_val = 1'b0;
      for (int i = 0; i < 5; i++) begin
         c_rd_val = 1'b1;
         c_rd_adr = 3'(i);
         cyc();
         dexp = 8'hA0 + 8'(i);
         checks++;
         if (c_rd_val_o !== 1'b1 || c_rd_dat_o !== dexp) begin
            errors++;
            $display("FAIL nonpow2_word[%0d]: val=%b dat=%h, required val=1 dat=%h", i, c_rd_val_o, c_rd_dat_o, dexp);
         end
      end
      c_rd_adr = 3'd6;
      cyc();
      checks++;
      if (c_rd_val_o !== 1'b1 || c_rd_dat_o !== 8'h00) begin
         errors++;
         $display("FAIL nonpow2_oor_read: val=%b dat=%h, required val=1 dat=00", c_rd_val_o, c_rd_dat_o);
      end
      c_rd_val = 1'b0;
      cyc();
   endtask

   task automatic test_reset_mid_read();
      b_rd_val = 1'b1; b_rd_adr = 2'd2;
      cyc();
      b_rd_val = 1'b0;
      rstn = 1'b0;
      #1;
      checks++;
      if (b_rd_val_o !== 1'b0) begin
         errors++;
         $display("FAIL midreset_async: val=%b, required 0", b_rd_val_o);
      end
      for (int k = 0; k < 2; k++) begin
         cyc();
         checks++;
         if (b_rd_val_o !== 1'b0 || b_rd_dat_o !== 8'h00) begin
            errors++;
            $display("FAIL midreset_hold[%0d]: val=%b dat=%h, required val=0 dat=00", k, b_rd_val_o, b_rd_dat_o);
         end
      end
      rstn = 1'b1;
      cyc();
      checks++;
      if (b_rd_val_o !== 1'b0) begin
         errors++;
         $display("FAIL midreset_release: val=%b, required 0", b_rd_val_o);
      end
      b_rd_val = 1'b1; b_rd_adr = 2'd2;
      a_rd_val = 1'b1; a_rd_adr = 2'd3;
      c_rd_val = 1'b1; c_rd_adr = 3'd4;
      cyc();
      b_rd_val = 1'b0; a_rd_val = 1'b0; c_rd_val = 1'b0;
      checks++;
      if (a_rd_val_o !== 1'b1 || a_rd_dat_o !== 8'h00) begin
         errors++;
         $display("FAIL midreset_mem_a: val=%b dat=%h, required val=1 dat=00", a_rd_val_o, a_rd_dat_o);
      end
      checks++;
      if (c_rd_val_o !== 1'b1 || c_rd_dat_o !== 8'h00) begin
         errors++;
         $display("FAIL midreset_mem_c: val=%b dat=%h, required val=1 dat=00", c_rd_val_o, c_rd_dat_o);
      end
      cyc();
      checks++;
      if (b_rd_val_o !== 1'b1 || b_rd_dat_o !== 8'h00) begin
         errors++;
         $display("FAIL midreset_mem_b: val=%b dat=%h, required val=1 dat=00", b_rd_val_o, b_rd_dat_o);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rstn = 1'b0;
      a_wr_val = 1'b0; a_wr_adr = '0; a_wr_dat = '0; a_rd_val = 1'b0; a_rd_adr = '0;
      b_wr_val = 1'b0; b_wr_adr = '0; b_wr_dat = '0; b_rd_val = 1'b0; b_rd_adr = '0;
      c_wr_val = 1'b0; c_wr_adr = '0; c_wr_dat = '0; c_rd_val = 1'b0; c_rd_adr = '0;
      test_reset();
      test_fill_readback();
      test_collision();
      test_latency();
      test_back_to_back();
      test_nonpow2();
      test_reset_mid_read();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
